// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// The lookup is combinational, for the IF stage. The update is registered and driven from EX.
// Optional macro BTB_GSHARE_EN adds a global history register. When it is set,
// the history is XORed into the lookup index and updates use the index captured at fetch.

// One BTB entry: valid/tag/target/counter, plus its update policy.
module btb_entry #(
  parameter int ADDR_W = 30,
  parameter int TAG_W  = 26,
  parameter int CNT_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [ADDR_W-1:0] target,
  output logic [CNT_W-1:0]  cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W-1);

  logic upd_hit;
  assign upd_hit = valid && (tag == upd_tag);

  // Train on hit, allocate on taken miss, and ignore a not-taken miss.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      cnt    <= '0;
    end else if (we) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          target <= upd_target;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end else if (upd_taken) begin
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        cnt    <= CNT_WEAK;
      end
    end
  end
endmodule

module branch_target_buffer #(
  parameter int ADDR_W  = 30,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = ADDR_W - IDX_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  output logic [IDX_W-1:0]  lk_idx,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);
  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_q;
  logic [ENTRIES-1:0][CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]               upd_sel;
  logic                           unused_upd;

`ifdef BTB_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] ghr_nxt;

  if (IDX_W == 1) begin : g_ghr1
    assign ghr_nxt = upd_taken;
  end else begin : g_ghrn
    assign ghr_nxt = {ghr[IDX_W-2:0], upd_taken};
  end

  // Shift every resolved outcome into the global history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         ghr <= '0;
    else if (upd_en) ghr <= ghr_nxt;
  end

  assign lk_idx     = lk_pc[IDX_W-1:0] ^ ghr;
  assign upd_sel    = upd_idx;
  assign unused_upd = ^upd_pc[IDX_W-1:0];
`else
  assign lk_idx     = lk_pc[IDX_W-1:0];
  assign upd_sel    = upd_pc[IDX_W-1:0];
  assign unused_upd = ^upd_idx;
`endif

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    btb_entry #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_ent (
      .CLK        (CLK),
      .RST        (RST),
      .we         (upd_en && (upd_sel == IDX_W'(i))),
      .upd_tag    (upd_pc[ADDR_W-1:IDX_W]),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .valid      (valid_q[i]),
      .tag        (tag_q[i]),
      .target     (target_q[i]),
      .cnt        (cnt_q[i])
    );
  end

  // The lookup reads the pre-edge state, so a same-cycle update is visible only after the edge.
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_pc[ADDR_W-1:IDX_W]);
  assign lk_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign lk_target = lk_hit ? target_q[lk_idx] : '0;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed vectors push expected
// lookup results, and a negedge monitor pops and compares them.
module tb_branch_target_buffer;
  localparam int ADDR_W = 30;
  localparam int IDX_W  = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [ADDR_W-1:0] lk_pc = '0;
  logic              lk_hit, lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic [IDX_W-1:0]  lk_idx;
  logic              upd_en = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic              chk = 1'b0;

  typedef struct {
    string             nm;
    logic              hit;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [IDX_W-1:0]  idx;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  branch_target_buffer #(.ADDR_W(ADDR_W), .ENTRIES(16), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .lk_target(lk_target), .lk_idx(lk_idx), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 CLK = ~CLK;

  // Monitor: compare each flagged lookup against the head of the scoreboard.
  always @(negedge CLK) begin
    if (chk) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: lookup flagged with no expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (lk_hit !== e.hit || lk_taken !== e.taken || lk_target !== e.target || lk_idx !== e.idx) begin
          n_fail++;
          $display("FAIL %s: got hit=%b taken=%b target=%h idx=%h, expected hit=%b taken=%b target=%h idx=%h",
                   e.nm, lk_hit, lk_taken, lk_target, lk_idx, e.hit, e.taken, e.target, e.idx);
        end
      end
    end
  end

  // One cycle: drive the update and lookup inputs, and optionally expect a lookup result.
  task automatic step(input bit ue, input logic [ADDR_W-1:0] upc, input bit ut,
                      input logic [ADDR_W-1:0] utg, input logic [IDX_W-1:0] uidx,
                      input bit ck, input logic [ADDR_W-1:0] lpc, input bit eh, input bit et,
                      input logic [ADDR_W-1:0] etg, input logic [IDX_W-1:0] ei, input string nm);
    exp_t e;
    @(posedge CLK); #1;
    upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_idx = uidx;
    lk_pc = lpc; chk = ck;
    if (ck) begin
      e.nm = nm; e.hit = eh; e.taken = et; e.target = etg; e.idx = ei;
      q.push_back(e);
    end
  endtask

  // Lookup-only cycle.
  task automatic look(input logic [ADDR_W-1:0] lpc, input bit eh, input bit et,
                      input logic [ADDR_W-1:0] etg, input logic [IDX_W-1:0] ei, input string nm);
    step(0, '0, 0, '0, '0, 1, lpc, eh, et, etg, ei, nm);
  endtask

  // Assert reset asynchronously in mid-cycle while an update is pending, then release it.
  task automatic reset_mid_update(input logic [ADDR_W-1:0] upc, input logic [IDX_W-1:0] uidx);
    @(posedge CLK); #1;
    chk = 0; upd_en = 1; upd_pc = upc; upd_idx = uidx; upd_taken = 1; upd_target = 30'h600;
    #2 RST = 1;
    @(posedge CLK); #1;
    upd_en = 0;
    RST = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // The lookup checked while reset is held must show no hit.
    look(30'h100, 0, 0, '0, 4'h0, "reset_lookup");
    @(posedge CLK); #1; chk = 0; RST = 0;
`ifndef BTB_GSHARE_EN
    step(1, 30'h104, 1, 30'h200, '0, 1, 30'h104, 0, 0, '0, 4'h4, "alloc_pre");
    look(30'h104, 1, 1, 30'h200, 4'h4, "alloc_weak_taken");
    // Counter walks down from 2: 1, 0, 0.
    step(1, 30'h104, 0, '0, '0, 1, 30'h104, 1, 1, 30'h200, 4'h4, "cnt2");
    step(1, 30'h104, 0, '0, '0, 1, 30'h104, 1, 0, 30'h200, 4'h4, "cnt1");
    step(1, 30'h104, 0, '0, '0, 1, 30'h104, 1, 0, 30'h200, 4'h4, "cnt0");
    // Counter climbs: 1, 2, 3, then stays at 3.
    step(1, 30'h104, 1, 30'h200, '0, 1, 30'h104, 1, 0, 30'h200, 4'h4, "cnt0_sat");
    step(1, 30'h104, 1, 30'h200, '0, 1, 30'h104, 1, 0, 30'h200, 4'h4, "cnt1_up");
    step(1, 30'h104, 1, 30'h200, '0, 1, 30'h104, 1, 1, 30'h200, 4'h4, "cnt2_up");
    step(1, 30'h104, 1, 30'h200, '0, 1, 30'h104, 1, 1, 30'h200, 4'h4, "cnt3");
    // A not-taken hit must keep the stored target. Going 3 -> 2 -> 1 shows that the counter did not wrap at 3.
    step(1, 30'h104, 0, 30'h3ff, '0, 1, 30'h104, 1, 1, 30'h200, 4'h4, "cnt3_sat");
    step(1, 30'h104, 0, '0, '0, 1, 30'h104, 1, 1, 30'h200, 4'h4, "nt_keeps_target");
    look(30'h104, 1, 0, 30'h200, 4'h4, "cnt1_after_sat");
    // A same-cycle update is invisible to this lookup and visible on the next one.
    step(1, 30'h104, 1, 30'h300, '0, 1, 30'h104, 1, 0, 30'h200, 4'h4, "same_cycle_old");
    look(30'h104, 1, 1, 30'h300, 4'h4, "same_cycle_new");
    // Aliasing on index 4.
    step(1, 30'h114, 1, 30'h400, '0, 1, 30'h104, 1, 1, 30'h300, 4'h4, "alias_pre");
    look(30'h114, 1, 1, 30'h400, 4'h4, "alias_new_hit");
    step(1, 30'h124, 0, 30'h500, '0, 1, 30'h104, 0, 0, '0, 4'h4, "alias_old_miss");
    look(30'h114, 1, 1, 30'h400, 4'h4, "nt_miss_no_change");
    look(30'h124, 0, 0, '0, 4'h4, "nt_miss_no_alloc");
    look(30'h3fffffff, 0, 0, '0, 4'hf, "idx_top");
    // A reset in mid-update wins.
    reset_mid_update(30'h114, '0);
    look(30'h114, 0, 0, '0, 4'h4, "reset_mid_update");
`else
    // Starting from GHR=0: the first update lands in entry 4, and GHR becomes 1.
    step(1, 30'h104, 1, 30'h200, 4'h4, 1, 30'h3, 0, 0, '0, 4'h3, "gs_idx_ghr0");
    // GHR=1: 0x105 ^ 1 -> index 4, tag 0x10, so it hits. GHR then becomes 3.
    step(1, 30'h108, 1, 30'h300, 4'h9, 1, 30'h105, 1, 1, 30'h200, 4'h4, "gs_hit_ghr1");
    // GHR=3: 0x107 ^ 3 -> index 4, and it hits. A not-taken miss makes GHR 6.
    step(1, 30'h10c, 0, '0, 4'h2, 1, 30'h107, 1, 1, 30'h200, 4'h4, "gs_hit_ghr3");
    look(30'h3, 0, 0, '0, 4'h5, "gs_idx_ghr6");
    look(30'h104, 0, 0, '0, 4'h2, "gs_104_ghr6");
    reset_mid_update(30'h104, 4'h4);
    look(30'h3, 0, 0, '0, 4'h3, "gs_reset_ghr0");
    look(30'h104, 0, 0, '0, 4'h4, "gs_reset_miss");
`endif
    @(posedge CLK); #1; chk = 0; upd_en = 0;
    @(negedge CLK);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised branch target buffer with per-entry saturating-counter direction predictors; successor to the fixed 4-entry, 2-bit predictor entry format.
- Lookup port is combinational in IF: given the fetch word address it returns hit, predicted direction and target.
- Update port is driven from EX once a branch resolves.
- Entries, counter width and address width are parameters.

Parameters:
ADDR_W, 30, word-address width (byte address bits [31:2])
ENTRIES, 16, number of direct-mapped entries; power of 2, >= 2
IDX_W, $clog2(ENTRIES), index width (derived localparam)
CNT_W, 2, saturating counter width, >= 1
TAG_W, ADDR_W-IDX_W, tag width (derived localparam)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
lk_pc  in  ADDR_W  fetch word address for lookup
lk_hit  out  1  valid entry whose tag matches lk_pc
lk_taken  out  1  predict taken (lk_hit & counter MSB)
lk_target  out  ADDR_W  stored target word address; 0 when !lk_hit
lk_idx  out  IDX_W  index used for this lookup; carried down the pipeline
upd_en  in  1  one branch resolved this cycle
upd_pc  in  ADDR_W  word address of the resolved branch
upd_idx  in  IDX_W  lk_idx captured when this branch was fetched
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual target word address

Behaviour:
- One clock CLK; reset RST is asynchronous and active-high.
- Storage per entry: valid, tag[TAG_W], target[ADDR_W], cnt[CNT_W].
- Reset, asynchronous: all valid=0, tags, targets and cnt=0, GHR=0 when enabled. All lookup outputs are therefore 0 while RST is high or immediately after it, except lk_idx, which follows lk_pc.
- Index without the feature: lk_idx = lk_pc[IDX_W-1:0]. The update index is upd_pc[IDX_W-1:0], and upd_idx is ignored.
- Tag is always pc[ADDR_W-1:IDX_W].
- Lookup: purely combinational, zero latency. lk_hit = valid[idx] & (tag[idx]==lk_pc tag). lk_taken = lk_hit & cnt[idx][CNT_W-1].
- Update is registered and takes effect at the rising CLK edge where upd_en=1.
  - Hit (valid and tag match), taken: cnt = min(cnt+1, 2^CNT_W-1); target = upd_target.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate and overwrite any existing entry. valid=1, tag=upd tag, target=upd_target, cnt = 2^(CNT_W-1) (weak taken).
  - Miss, not taken: no change.
- Counter saturates at both ends and never wraps.
- Lookup and update to the same index in the same cycle: lookup sees pre-update contents. The new value is visible the cycle after the edge (write-then-read across edges, no bypass).
- Entries are never invalidated except by reset.
- RST asserted mid-update: reset wins, and the update is lost.

Optional Feature:
- BTB_GSHARE_EN defined:
  - Adds an IDX_W-bit global history register, GHR.
  - lk_idx = lk_pc[IDX_W-1:0] ^ GHR.
  - Updates use upd_idx for the entry index. Tag compare is unchanged.
  - On every upd_en edge: GHR = {GHR[IDX_W-2:0], upd_taken}. For IDX_W=1, GHR = upd_taken.
  - GHR resets to 0.
- BTB_GSHARE_EN undefined: no GHR; behaviour as above, and upd_idx is unused.

Test Plan:
- Reset then lookup lk_pc=0x100 -> lk_hit=0, lk_taken=0, lk_target=0.
- Update pc=0x104, taken, target=0x200; next cycle lookup 0x104 -> hit=1, taken=1, target=0x200, cnt=2.
- Three not-taken updates on 0x104 from cnt=2 -> cnt 1, 0, 0 (saturated); lk_taken=0 after the first. Then three taken updates -> cnt 1, 2, 3; a fourth taken keeps 3.
- Aliasing with ENTRIES=16: entry for 0x104 present; taken update pc=0x114 (same index, different tag) -> 0x114 hits with target from the update; 0x104 now misses. A not-taken miss on 0x124 -> no change, 0x114 still hits.
- Same-cycle lookup and update of 0x104 (taken, new target 0x300) -> that cycle shows the old target 0x200; next cycle shows 0x300.
- BTB_GSHARE_EN: updates taken, taken, not-taken -> GHR=0b0110 (IDX_W=4); lookup pc=0x3 -> lk_idx=0x5. Assert RST mid-sequence -> GHR=0 and all entries miss.
